// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: per-stage stall requests and the MEM exception inputs flowing in,
// plus the stall/flush/redirect controls and perf counters flowing back to the pipeline.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        mem_inst_valid;
  logic [1:0]  mem_excepttype;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mem_cancel;
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flush_count;

  // Pipeline side: raises requests, consumes controls.
  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output mem_inst_valid, mem_excepttype, csr_eentry, csr_era,
    input  stall, flush, new_pc, mem_cancel, perf_stall_cycles, perf_flush_count
  );

  // Controller side.
  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  mem_inst_valid, mem_excepttype, csr_eentry, csr_era,
    output stall, flush, new_pc, mem_cancel, perf_stall_cycles, perf_flush_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stall requests and turns MEM exceptions into a one-cycle
// flush with a latched redirect PC. Define PIPE_CTRL_PERF_EN to build the perf counters.
module pipe_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [5:0]  stall_mask;
  logic [5:0]  stall;
  logic        flush;
  logic        mem_cancel;
  logic        accept;

  // Higher stages' masks are supersets of lower ones, so the OR lets the highest requester win.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    stall_mask = 6'b000000;
    if (bus.stallreq_if)  stall_mask = stall_mask | 6'b000111;
    if (bus.stallreq_id)  stall_mask = stall_mask | 6'b001111;
    if (bus.stallreq_ex)  stall_mask = stall_mask | 6'b011111;
    if (bus.stallreq_mem) stall_mask = stall_mask | 6'b111111;
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    stall      = stall_mask;
    flush      = 1'b0;
    mem_cancel = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        // A stalled MEM instruction is not yet committed, so its exception waits for release.
        accept = bus.mem_inst_valid && (bus.mem_excepttype != 2'b00) && !bus.stallreq_mem;
        if (accept) begin
          state_d    = FLUSH;
          target_d   = (bus.mem_excepttype == 2'b10) ? bus.csr_era : bus.csr_eentry;
          mem_cancel = 1'b1;
        end
      end
      FLUSH: begin
        state_d    = IDLE;
        stall      = 6'b000000;
        flush      = 1'b1;
        mem_cancel = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset here is synchronous, active-high.
    if (rst) begin
      state_q  <= IDLE;
      target_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  assign bus.stall      = stall;
  assign bus.flush      = flush;
  assign bus.new_pc     = target_q;
  assign bus.mem_cancel = mem_cancel;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_flush_q, perf_flush_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if ((stall != 6'b000000) && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
    if (flush && (perf_flush_q != '1))                perf_flush_d = perf_flush_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign bus.perf_stall_cycles = perf_stall_q;
  assign bus.perf_flush_count  = perf_flush_q;
`else
  assign bus.perf_stall_cycles = 32'd0;
  assign bus.perf_flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stimulus pushes hand-computed expectations per cycle into a
// scoreboard queue; a monitor pops and compares mid-cycle.
module tb_pipe_ctrl;

  localparam logic [31:0] RST_PC = 32'h1c000000;
  localparam logic [31:0] EENTRY = 32'h1c008000;
  localparam logic [31:0] EENTRY2 = 32'h1c00a000;
  localparam logic [31:0] ERA    = 32'h1c000100;
`ifdef PIPE_CTRL_PERF_EN
  localparam logic [31:0] PS_EXP = 32'd5;
  localparam logic [15:0] PF_EXP = 16'd2;
`else
  localparam logic [31:0] PS_EXP = 32'd0;
  localparam logic [15:0] PF_EXP = 16'd0;
`endif

  typedef struct {
    string       tag;
    logic [5:0]  stall;
    logic        flush;
    logic        mc;
    logic [31:0] pc;
    bit          chk_perf;
    logic [31:0] ps;
    logic [15:0] pf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pipe_ctrl_if bus ();

  pipe_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   perf_chk = 1'b0;
  logic [31:0] perf_ps = '0;
  logic [15:0] perf_pf = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare whatever the stimulus queued.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, ".stall"}, {26'd0, bus.stall}, {26'd0, e.stall});
      check({e.tag, ".flush"}, {31'd0, bus.flush}, {31'd0, e.flush});
      check({e.tag, ".mem_cancel"}, {31'd0, bus.mem_cancel}, {31'd0, e.mc});
      check({e.tag, ".new_pc"}, bus.new_pc, e.pc);
      if (e.chk_perf) begin
        check({e.tag, ".perf_stall"}, bus.perf_stall_cycles, e.ps);
        check({e.tag, ".perf_flush"}, {16'd0, bus.perf_flush_count}, {16'd0, e.pf});
      end
    end
  end

  // req = {mem, ex, id, if}
  task automatic cyc(input string tag, input logic r, input logic [3:0] req, input logic v,
                     input logic [1:0] et, input logic [31:0] ee, input logic [5:0] es,
                     input logic ef, input logic emc, input logic [31:0] epc);
    exp_t e;
    @(posedge clk);
    #1;
    rst                = r;
    bus.stallreq_if    = req[0];
    bus.stallreq_id    = req[1];
    bus.stallreq_ex    = req[2];
    bus.stallreq_mem   = req[3];
    bus.mem_inst_valid = v;
    bus.mem_excepttype = et;
    bus.csr_eentry     = ee;
    e.tag = tag; e.stall = es; e.flush = ef; e.mc = emc; e.pc = epc;
    e.chk_perf = perf_chk; e.ps = perf_ps; e.pf = perf_pf;
    sb.push_back(e);
  endtask

  initial begin
    bus.stallreq_if = 0; bus.stallreq_id = 0; bus.stallreq_ex = 0; bus.stallreq_mem = 0;
    bus.mem_inst_valid = 0; bus.mem_excepttype = 2'b00;
    bus.csr_eentry = EENTRY; bus.csr_era = ERA;
    repeat (2) @(posedge clk);

    perf_chk = 1'b1;
    cyc("reset",       0, 4'b0000, 0, 2'b00, EENTRY, 6'b000000, 0, 0, RST_PC);
    perf_chk = 1'b0;
    cyc("st_id",       0, 4'b0010, 0, 2'b00, EENTRY, 6'b001111, 0, 0, RST_PC);
    cyc("st_id_ex",    0, 4'b0110, 0, 2'b00, EENTRY, 6'b011111, 0, 0, RST_PC);
    cyc("st_all",      0, 4'b1111, 0, 2'b00, EENTRY, 6'b111111, 0, 0, RST_PC);
    cyc("st_none",     0, 4'b0000, 0, 2'b00, EENTRY, 6'b000000, 0, 0, RST_PC);
    cyc("st_if",       0, 4'b0001, 0, 2'b00, EENTRY, 6'b000111, 0, 0, RST_PC);
    cyc("st_mem",      0, 4'b1000, 0, 2'b00, EENTRY, 6'b111111, 0, 0, RST_PC);
    // Exception redirect to eentry.
    cyc("exc_acc",     0, 4'b0000, 1, 2'b01, EENTRY, 6'b000000, 0, 1, RST_PC);
    cyc("exc_flush",   0, 4'b0000, 0, 2'b00, EENTRY, 6'b000000, 1, 1, EENTRY);
    cyc("exc_after",   0, 4'b0000, 0, 2'b00, EENTRY, 6'b000000, 0, 0, EENTRY);
    // ertn with a concurrent ID stall; exception and stall during FLUSH are ignored.
    cyc("ertn_acc",    0, 4'b0010, 1, 2'b10, EENTRY, 6'b001111, 0, 1, EENTRY);
    cyc("ertn_flush",  0, 4'b0100, 1, 2'b01, EENTRY, 6'b000000, 1, 1, ERA);
    cyc("ertn_after",  0, 4'b0000, 0, 2'b00, EENTRY, 6'b000000, 0, 0, ERA);
    // Exception blocked while MEM stalls.
    cyc("blk_0",       0, 4'b1000, 1, 2'b01, EENTRY, 6'b111111, 0, 0, ERA);
    cyc("blk_1",       0, 4'b1000, 1, 2'b01, EENTRY, 6'b111111, 0, 0, ERA);
    cyc("blk_2",       0, 4'b1000, 1, 2'b01, EENTRY, 6'b111111, 0, 0, ERA);
    cyc("blk_acc",     0, 4'b0000, 1, 2'b01, EENTRY, 6'b000000, 0, 1, ERA);
    cyc("blk_flush",   0, 4'b0000, 0, 2'b00, EENTRY, 6'b000000, 1, 1, EENTRY);
    cyc("blk_after",   0, 4'b0000, 0, 2'b00, EENTRY, 6'b000000, 0, 0, EENTRY);
    // Reserved type behaves as exception; reset lands in the FLUSH cycle.
    cyc("rsv_acc",     0, 4'b0000, 1, 2'b11, EENTRY2, 6'b000000, 0, 1, EENTRY);
    cyc("rst_flush",   1, 4'b0000, 0, 2'b00, EENTRY, 6'b000000, 1, 1, EENTRY2);
    perf_chk = 1'b1; perf_ps = '0; perf_pf = '0;
    cyc("rst_after",   0, 4'b0000, 0, 2'b00, EENTRY, 6'b000000, 0, 0, RST_PC);
    perf_chk = 1'b0;
    // Exception without a valid instruction is ignored.
    cyc("inv_exc",     0, 4'b0000, 0, 2'b01, EENTRY, 6'b000000, 0, 0, RST_PC);
    cyc("inv_after",   0, 4'b0000, 0, 2'b00, EENTRY, 6'b000000, 0, 0, RST_PC);
    // Perf: five stall cycles, then two exceptions accepted at T and T+2.
    for (int i = 0; i < 5; i++)
      cyc("perf_st",   0, 4'b0001, 0, 2'b00, EENTRY, 6'b000111, 0, 0, RST_PC);
    cyc("perf_acc0",   0, 4'b0000, 1, 2'b01, EENTRY, 6'b000000, 0, 1, RST_PC);
    cyc("perf_fl0",    0, 4'b0000, 0, 2'b00, EENTRY, 6'b000000, 1, 1, EENTRY);
    cyc("perf_acc1",   0, 4'b0000, 1, 2'b10, EENTRY, 6'b000000, 0, 1, EENTRY);
    cyc("perf_fl1",    0, 4'b0000, 0, 2'b00, EENTRY, 6'b000000, 1, 1, ERA);
    perf_chk = 1'b1; perf_ps = PS_EXP; perf_pf = PF_EXP;
    cyc("perf_end",    0, 4'b0000, 0, 2'b00, EENTRY, 6'b000000, 0, 0, ERA);
    perf_chk = 1'b0;

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the six-register in-order pipeline (PC, pc_if, if_id, id_ex, ex_mem, mem_wb). It merges per-stage stall requests into the shared `stall[5:0]` vector. It sequences exception redirects from the MEM stage into a registered one-cycle `flush` pulse with a latched redirect PC. Every pipeline register, including ex_mem, consumes `stall` and `flush` from this block.

## Interface
Parameters:
- `RESET_PC`, 32'h1c000000, value driven on `new_pc` after reset.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `stallreq_if`  in  1  IF stage not ready
- `stallreq_id`  in  1  ID stage load-use or operand hazard
- `stallreq_ex`  in  1  EX multi-cycle op (div/mul) busy
- `stallreq_mem`  in  1  MEM stage waiting on data memory
- `mem_inst_valid`  in  1  MEM stage holds a valid instruction
- `mem_excepttype`  in  2  00 none, 01 exception, 10 ertn, 11 reserved (treated as 01)
- `csr_eentry`  in  32  exception entry address
- `csr_era`  in  32  exception return address
- `stall`  out  6  per-register stop; 1 = Stop
- `flush`  out  1  clear all pipeline registers
- `new_pc`  out  32  redirect target, valid while `flush`=1
- `mem_cancel`  out  1  suppress memory/regfile side effects of the instruction in MEM
- `perf_stall_cycles`  out  32  stall-cycle counter (see Configuration)
- `perf_flush_count`  out  16  flush counter (see Configuration)

## Operation
- Stall masks, OR-combined:
  - `stallreq_if` -> 6'b000111
  - `stallreq_id` -> 6'b001111
  - `stallreq_ex` -> 6'b011111
  - `stallreq_mem` -> 6'b111111
- Stall mask rule: a register i with stall[i]=1 and stall[i+1]=0 inserts a bubble. A register with both bits set holds. The highest requesting stage therefore dominates.
- Exception accept condition, in IDLE only: `mem_inst_valid`=1, `mem_excepttype`!=00 and `stallreq_mem`=0. An exception while MEM is stalled waits until the stall releases.
- FSM states:
  - IDLE: on accept, latch the target and go to FLUSH. Target is `csr_era` for type 10, `csr_eentry` for types 01/11.
  - FLUSH: lasts exactly one cycle, then returns to IDLE unconditionally. While in FLUSH:
    - `flush`=1, `new_pc`=latched target, `stall`=6'b000000.
    - `mem_cancel`=1.
    - All stall requests and exceptions are ignored.
- `mem_cancel`=1 combinationally in the accept cycle, so the excepting instruction commits nothing. It stays high through FLUSH, so the younger instruction entering MEM also commits nothing.
- `new_pc` holds its last latched value outside FLUSH.

## Timing
- Reset values:
  - `stall`=0, `flush`=0, `mem_cancel`=0.
  - `new_pc`=`RESET_PC`, FSM=IDLE.
  - Both perf counters 0.
- Stall path: combinational, zero latency from request to `stall`.
- Exception path:
  - Accept at cycle T: `mem_cancel`=1 at T.
  - `flush`=1 with valid `new_pc` at T+1, for one cycle only.
  - Earliest next accept is T+2.
- Back-to-back exceptions are impossible in consecutive cycles. The exception in MEM at T+1 is flushed and never accepted.
- Stall and exception in the same cycle with `stallreq_mem`=0: the exception is accepted and `stall` follows the mask rule at T. At T+1 `flush` overrides and `stall`=0.
- `rst` during FLUSH: the next cycle is IDLE, `flush`=0 and the latched target is discarded.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `perf_stall_cycles` increments each cycle `stall`!=0.
  - `perf_flush_count` increments each cycle `flush`=1.
  - Both counters saturate at all-ones and are cleared only by `rst`.
- `PIPE_CTRL_PERF_EN` undefined: both outputs are constant 0 and no counter registers are built.

## Test plan
- Stall masks: single `stallreq_id`=1 -> `stall`=6'b001111. Then `stallreq_id`+`stallreq_ex` -> 6'b011111. Then all four -> 6'b111111. Then none -> 6'b000000, same cycle each time.
- Exception redirect: `mem_excepttype`=01 with `mem_inst_valid`=1 and `csr_eentry`=32'h1c008000 at T -> `mem_cancel`=1 at T. At T+1, `flush`=1 and `new_pc`=32'h1c008000. At T+2, `flush`=0.
- ertn redirect: type 10 with `csr_era`=32'h1c000100 -> `new_pc`=32'h1c000100 during the flush cycle.
- Exception blocked by MEM stall: exception with `stallreq_mem`=1 held for 3 cycles -> `stall`=6'b111111 and `flush`=0 throughout. The flush occurs one cycle after `stallreq_mem` drops.
- Reset and exception suppression:
  - `rst` asserted in the FLUSH cycle -> next cycle all outputs are at reset values.
  - Exception presented during FLUSH -> ignored, only one flush pulse.
- Perf counters, with `PIPE_CTRL_PERF_EN` defined: 5 stall cycles plus 2 exceptions -> `perf_stall_cycles`=5 and `perf_flush_count`=2.
